// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: synchroniser, per-channel debounce FSM,
// registered press/release ticks, long-press hold detection and auto-repeat.
module debounce_multi #(
  parameter int NCH    = 4,
  parameter int N      = 21,
  parameter int SYNC   = 2,
  parameter int HOLD_N = 25,
  parameter int RPT_N  = 23,
  parameter int RPT_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] press_tick,
  output logic [NCH-1:0] release_tick,
  output logic [NCH-1:0] hold_tick,
  output logic [NCH-1:0] repeat_tick,
  output logic           any_level
);

  // state | meaning
  // IDLE  | debounced low, input low
  // DLY0  | input went high, timing stable-high before press
  // ONE   | debounced high, hold counter running while input high
  // DLY1  | input went low, timing stable-low before release
  typedef enum logic [1:0] {IDLE, DLY0, ONE, DLY1} state_t;

  localparam int H = (HOLD_N > RPT_N) ? HOLD_N : RPT_N;
  localparam logic [H-1:0] HOLD_MAX = H'((64'd1 << HOLD_N) - 64'd1);
  localparam logic [H-1:0] RPT_MAX  = H'((64'd1 << RPT_N) - 64'd1);

  logic [NCH-1:0] sw_s;

  generate
    if (SYNC == 0) begin : g_nosync
      assign sw_s = sw;
    end else begin : g_sync
      logic [SYNC-1:0][NCH-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sw;
          for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sw_s = sync_q[SYNC-1];
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      state_t       state_q, state_d;
      logic [N-1:0] timer_q, timer_d;
      logic [H-1:0] cnt_q, cnt_d;
      logic         held_q, held_d;
      logic         press_q, press_d;
      logic         rel_q, rel_d;
      logic         hold_q, hold_d;
      logic         rpt_q, rpt_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          timer_q <= '0;
          cnt_q   <= '0;
          held_q  <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          hold_q  <= 1'b0;
          rpt_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
          cnt_q   <= cnt_d;
          held_q  <= held_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          hold_q  <= hold_d;
          rpt_q   <= rpt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        hold_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
          IDLE: begin
            if (sw_s[g]) begin
              timer_d = '0;
              state_d = DLY0;
            end
          end
          DLY0: begin
            if (!sw_s[g]) begin
              state_d = IDLE;
            end else begin
              timer_d = timer_q + 1'b1;
              if (timer_q == '1) begin
                state_d = ONE;
                cnt_d   = '0;
                held_d  = 1'b0;
                press_d = 1'b1;
              end
            end
          end
          ONE: begin
            if (!sw_s[g]) begin
              timer_d = '0;
              state_d = DLY1;
            end else if (!held_q && cnt_q == HOLD_MAX) begin
              hold_d = 1'b1;
              held_d = 1'b1;
              cnt_d  = '0;
            end else if (held_q && (RPT_EN != 0) && cnt_q == RPT_MAX) begin
              rpt_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          DLY1: begin
            // hold counter stays frozen here so a release glitch only delays hold/repeat
            if (sw_s[g]) begin
              state_d = ONE;
            end else begin
              timer_d = timer_q + 1'b1;
              if (timer_q == '1) begin
                state_d = IDLE;
                rel_d   = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end

      assign db_level[g]     = (state_q == ONE) || (state_q == DLY1);
      assign press_tick[g]   = press_q;
      assign release_tick[g] = rel_q;
      assign hold_tick[g]    = hold_q;
      assign repeat_tick[g]  = rpt_q;
    end
  endgenerate

  assign any_level = |db_level;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with short timers (N=3, SYNC=2, HOLD_N=4, RPT_N=3).
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] db_level, press_tick, release_tick, hold_tick, repeat_tick;
  logic       any_level;

  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .NCH(4), .N(3), .SYNC(2), .HOLD_N(4), .RPT_N(3), .RPT_EN(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .db_level(db_level),
    .press_tick(press_tick),
    .release_tick(release_tick),
    .hold_tick(hold_tick),
    .repeat_tick(repeat_tick),
    .any_level(any_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int k, input logic [3:0] lvl,
                            input logic [3:0] pr, input logic [3:0] rl,
                            input logic [3:0] hd, input logic [3:0] rp);
    logic [20:0] exp_v, obs_v;
    exp_v = {lvl, pr, rl, hd, rp, |lvl};
    obs_v = {db_level, press_tick, release_tick, hold_tick, repeat_tick, any_level};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h (lvl,press,rel,hold,rpt,any)",
             tag, k, obs_v, exp_v);
    end
  endtask

  initial begin
    // reset state
    step();
    step();
    expect_out("reset", 0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_out("idle", k, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // clean press on ch0, hold, repeats, then release
    sw = 4'b0001;
    for (int k = 1; k <= 75; k++) begin
      step();
      expect_out("press_hold_release", k,
                 (k >= 11 && k <= 70) ? 4'b0001 : 4'b0000,
                 (k == 11) ? 4'b0001 : 4'b0000,
                 (k == 71) ? 4'b0001 : 4'b0000,
                 (k == 27) ? 4'b0001 : 4'b0000,
                 (k == 35 || k == 43 || k == 51 || k == 59) ? 4'b0001 : 4'b0000);
      if (k == 60) sw = 4'b0000;
    end

    // short bounce on ch1: never accepted
    sw = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out("short_bounce", k, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
      if (k == 5) sw = 4'b0000;
    end

    // release glitch on ch2 at hold count 5: hold delayed by 4 cycles
    sw = 4'b0100;
    for (int k = 1; k <= 45; k++) begin
      step();
      expect_out("release_glitch", k,
                 (k >= 11 && k <= 42) ? 4'b0100 : 4'b0000,
                 (k == 11) ? 4'b0100 : 4'b0000,
                 (k == 43) ? 4'b0100 : 4'b0000,
                 (k == 31) ? 4'b0100 : 4'b0000,
                 4'b0000);
      if (k == 14) sw = 4'b0000;
      if (k == 17) sw = 4'b0100;
      if (k == 32) sw = 4'b0000;
    end

    // simultaneous press on all channels, release only ch1, then drop all
    sw = 4'b1111;
    for (int k = 1; k <= 32; k++) begin
      step();
      expect_out("simultaneous", k,
                 (k < 11) ? 4'b0000 : ((k < 24) ? 4'b1111 : 4'b1101),
                 (k == 11) ? 4'b1111 : 4'b0000,
                 (k == 24) ? 4'b0010 : 4'b0000,
                 (k == 27) ? 4'b1101 : 4'b0000,
                 4'b0000);
      if (k == 13) sw = 4'b1101;
      if (k == 28) sw = 4'b0000;
    end

    // reset while ch0 is in DLY1, exit reset with all switches high
    rst_n = 1'b0;
    #1;
    expect_out("reset_mid", 0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    sw = 4'b1111;
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      expect_out("after_reset", k,
                 (k >= 11) ? 4'b1111 : 4'b0000,
                 (k == 11) ? 4'b1111 : 4'b0000,
                 4'b0000, 4'b0000, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel switch debouncer for pushbuttons and slide switches on the FPGA board. It is the parametrised successor of the single-channel explicit-FSM debouncer. Each channel adds an input synchroniser, registered press and release ticks, long-press (hold) detection and optional auto-repeat. It sits between the board pins and the UI/mode-control logic, for example SVGA mode select and counter stepping.

Parameters:
NCH, 4, number of independent channels (1..32)
N, 21, debounce timer bits; stable time is 2^N cycles (21 bits ≈ 42 ms at 50 MHz)
SYNC, 2, input synchroniser stages (0..3); 0 means sw is used directly
HOLD_N, 25, hold threshold is 2^HOLD_N cycles of debounced-high
RPT_N, 23, auto-repeat period is 2^RPT_N cycles after hold_tick
RPT_EN, 1, 1 enables repeat_tick; 0 ties repeat_tick to 0

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
sw  in  NCH  raw switch inputs, asynchronous to clk
db_level  out  NCH  debounced level per channel
press_tick  out  NCH  one-cycle pulse on debounced rising edge
release_tick  out  NCH  one-cycle pulse on debounced falling edge
hold_tick  out  NCH  one-cycle pulse when held for 2^HOLD_N cycles
repeat_tick  out  NCH  one-cycle pulse every 2^RPT_N cycles after hold
any_level  out  1  OR of db_level

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset clears all state, timers, hold counters, held flags and synchroniser flops to 0, and all outputs to 0. Reset asserted mid-operation aborts immediately; there are no ticks on reset exit.
- Channels are fully independent, each with its own FSM, timer, counter and flag. There is no shared arbitration.
- Synchroniser: sw_s[i] is sw[i] delayed through SYNC flops. If sw is high from cycle c, sw_s is high from cycle c+SYNC.
- Per-channel FSM states are IDLE, DLY0, ONE and DLY1. Timer is N bits.
- IDLE: if sw_s=1, load timer to 0 and go to DLY0.
- DLY0: if sw_s=0, go to IDLE. Otherwise increment the timer. If timer=all-ones, go to ONE, clear the hold counter and the held flag, and assert press_tick in the first cycle of ONE.
- ONE: if sw_s=1, increment the hold counter. If sw_s=0, load timer to 0 and go to DLY1 (hold counter does not increment that cycle).
- DLY1: if sw_s=1, go to ONE with the hold counter preserved. Otherwise increment the timer. If timer=all-ones, go to IDLE and assert release_tick in the first cycle of IDLE.
- db_level=1 in ONE and DLY1, and 0 in IDLE and DLY0. It is decoded from the registered state, so it is glitch-free.
- Ticks are registered and aligned with the state change. Sequence of levels and events: db_level rises and press_tick fires in the same cycle; db_level falls and release_tick fires in the same cycle.
- Press latency: sw high from cycle c, held stable, gives press_tick and first db_level=1 at cycle c+SYNC+2^N+1. Release latency follows the same rule.
- Hold counter width is H = max(HOLD_N, RPT_N). It increments only in ONE with sw_s=1 and is frozen in DLY1.
- While the held flag is 0: when the counter equals 2^HOLD_N-1 and is incrementing, next cycle hold_tick=1, the held flag is set and the counter is cleared.
- While the held flag is 1 and RPT_EN=1: when the counter equals 2^RPT_N-1 and is incrementing, next cycle repeat_tick=1 and the counter wraps to 0.
- hold_tick fires at most once per press. Ticks never occur in IDLE or DLY0.
- Bounce shorter than 2^N cycles on either edge produces no level change and no tick. Bounce during release delays hold/repeat ticks by the number of non-incrementing cycles.
- release_tick and hold_tick cannot coincide, because hold requires state ONE.
- Simultaneous events on different channels are all reported in the same cycle.

Test Plan:
Use N=3, SYNC=2, HOLD_N=4, RPT_N=3, RPT_EN=1, NCH=4.
1. Clean press: sw[0]=1 from cycle 10 and held -> press_tick[0] and db_level[0] rise at cycle 21; hold_tick at 37; repeat_tick at 45, 53, 61. No other channel toggles.
2. Short bounce: sw[1] high for 5 cycles, then low -> db_level[1], press_tick[1] and hold_tick[1] stay 0 throughout.
3. Release: after test 1, sw[0]=0 at cycle 70 -> db_level[0] stays 1 through cycle 80; release_tick[0] and db_level[0]=0 at cycle 81; no further repeat_tick.
4. Release glitch: in ONE at counter 5, sw[2] drops for 3 cycles -> no release_tick; db_level stays 1; hold_tick arrives exactly 4 cycles later than in the unglitched case.
5. Simultaneous and independent: sw[3:0]=4'b1111 at the same cycle -> press_tick=4'b1111 in one cycle; any_level=1; releasing only ch1 -> release_tick=4'b0010.
6. Reset mid-hold: assert rst_n=0 during DLY1 on ch0 -> all outputs 0 immediately. Release reset with sw=1 -> no ticks until a fresh press_tick at SYNC+2^N+1 cycles.
